// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - host-side initiator for a start/done compute engine
//
// Takes one operand set over a valid/ready input, presents it to the engine and
// holds start until done (or until the watchdog expires). The engine result, or
// an error marker on timeout, is then returned over a valid/ready result port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand set handshake, in_a..in_d operand payload
//   a, b, c, d               registered operands to the engine
//   start / done / out       engine request (level), completion (level), result
//   res_valid/res_ready      result handshake, res_data result, res_err timeout flag
//   job_cnt, err_cnt         wrapping counts of completed jobs and timeout aborts
module operand_sequencer #(
  parameter int W       = 16,
  parameter int RW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [W-1:0]  in_c,
  input  logic [W-1:0]  in_d,
  output logic [W-1:0]  a,
  output logic [W-1:0]  b,
  output logic [W-1:0]  c,
  output logic [W-1:0]  d,
  output logic          start,
  input  logic          done,
  input  logic [RW-1:0] out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [RW-1:0] res_data,
  output logic          res_err,
  output logic [15:0]   job_cnt,
  output logic [15:0]   err_cnt
);

  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [WDW-1:0] wd;
  logic           accept;
  logic           finish_ok;
  logic           finish_to;
  logic           handshake;

  // Handshake outputs decode straight from the state register.
  assign in_ready  = (state == IDLE);
  assign start     = (state == BUSY);
  assign res_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish_ok = 1'b0;
    finish_to = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // done is checked first so a completion on the last watchdog cycle is not an error
        if (done) begin
          finish_ok = 1'b1;
          state_nxt = RESP;
        end else if (wd == WD_LAST) begin
          finish_to = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (res_ready) begin
          handshake = 1'b1;
          // a done still high here belongs to the finished job; wait it out
          state_nxt = done ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (!done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd       <= '0;
      a        <= '0;
      b        <= '0;
      c        <= '0;
      d        <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
      job_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      if (accept) begin
        a  <= in_a;
        b  <= in_b;
        c  <= in_c;
        d  <= in_d;
        wd <= '0;
      end else if (state == BUSY) begin
        wd <= wd + 1'b1;
      end

      if (finish_ok) begin
        res_data <= out;
        res_err  <= 1'b0;
      end else if (finish_to) begin
        res_data <= '0;
        res_err  <= 1'b1;
      end

      if (handshake) begin
        job_cnt <= job_cnt + 16'd1;
        if (res_err) begin
          err_cnt <= err_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// tb/tb_operand_sequencer.sv - scoreboard bench for operand_sequencer with a behavioural engine
module tb_operand_sequencer;

  localparam int W       = 16;
  localparam int RW      = 32;
  localparam int TIMEOUT = 64;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a, in_b, in_c, in_d;
  logic [W-1:0]  a, b, c, d;
  logic          start;
  logic          done;
  logic [RW-1:0] out;
  logic          res_valid;
  logic          res_ready;
  logic [RW-1:0] res_data;
  logic          res_err;
  logic [15:0]   job_cnt;
  logic [15:0]   err_cnt;

  operand_sequencer #(.W(W), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .a(a), .b(b), .c(c), .d(d),
    .start(start), .done(done), .out(out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err),
    .job_cnt(job_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  a, b, c, d;
    logic [RW-1:0] data;
    logic          err;
    int            cycles;
  } exp_t;

  typedef struct {
    int            lat;
    int            hold;
    logic [RW-1:0] ov;
  } eng_t;

  exp_t exp_q[$];
  eng_t eng_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int stall_left = 0;
  logic [15:0] m_jobs = 0;
  logic [15:0] m_errs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Engine: raises done in the lat-th cycle of start, holds it for hold cycles after start drops.
  initial begin
    int   bc;
    int   hold_left;
    eng_t cur;
    done = 1'b0;
    out  = '0;
    bc = 0;
    hold_left = 0;
    cur.lat = 0; cur.hold = 0; cur.ov = '0;
    forever begin
      @(posedge clk); #1;
      if (start) begin
        if (bc == 0) begin
          if (eng_q.size() > 0) cur = eng_q.pop_front();
          else begin cur.lat = 0; cur.hold = 0; cur.ov = '0; end
        end
        bc++;
        if (cur.lat != 0 && bc >= cur.lat && !done) begin
          done = 1'b1;
          out = cur.ov;
          hold_left = cur.hold;
        end
      end else begin
        bc = 0;
        done = done && (hold_left > 0);
        if (hold_left > 0) hold_left--;
        if (!done) out = $urandom;
      end
    end
  end

  // Result consumer: res_ready low for stall_left cycles of res_valid, then high.
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      res_ready = (stall_left == 0);
      if (res_valid && stall_left > 0) stall_left--;
    end
  end

  // Monitor / scoreboard.
  initial begin
    int            cur_start;
    bit            prev_valid;
    logic [RW-1:0] held_data;
    logic          held_err;
    exp_t          e;
    cur_start = 0;
    prev_valid = 0;
    held_data = '0;
    held_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur_start = 0;
        prev_valid = 0;
        m_jobs = 0;
        m_errs = 0;
      end else begin
        if (in_ready) check("in_ready_exclusive", {61'd0, start, done, res_valid}, 64'd0);
        if (start) begin
          cur_start++;
          if (exp_q.size() == 0) check("start_without_job", 64'd1, 64'd0);
          else check("operands", {a, b, c, d}, {exp_q[0].a, exp_q[0].b, exp_q[0].c, exp_q[0].d});
        end
        if (res_valid) begin
          check("start_low_in_resp", {63'd0, start}, 64'd0);
          if (exp_q.size() == 0) begin
            check("result_without_job", 64'd1, 64'd0);
          end else begin
            e = exp_q[0];
            if (!prev_valid) begin
              check("res_data", 64'(res_data), 64'(e.data));
              check("res_err", {63'd0, res_err}, {63'd0, e.err});
              check("start_cycles", 64'(cur_start), 64'(e.cycles));
              held_data = res_data;
              held_err = res_err;
            end else begin
              check("res_stable", {31'd0, res_data, res_err}, {31'd0, held_data, held_err});
              check("in_ready_stall", {63'd0, in_ready}, 64'd0);
            end
            if (res_ready) begin
              check("job_cnt_pre", 64'(job_cnt), 64'(m_jobs));
              check("err_cnt_pre", 64'(err_cnt), 64'(m_errs));
              m_jobs = m_jobs + 16'd1;
              if (e.err) m_errs = m_errs + 16'd1;
              void'(exp_q.pop_front());
              cur_start = 0;
            end
          end
        end
        prev_valid = res_valid && !res_ready;
      end
    end
  end

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("results_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_job(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ic, input logic [W-1:0] id,
                        input int lat, input int hold, input int stall,
                        input logic [RW-1:0] ov);
    exp_t e;
    eng_t g;
    bit   ok;
    bit   taken;
    int   n;
    if (stall > 0) begin
      wait_empty();
      stall_left = stall;
      res_ready = 1'b0;
    end
    ok = (lat != 0) && (lat <= TIMEOUT);
    e.a = ia; e.b = ib; e.c = ic; e.d = id;
    e.data = ok ? ov : '0;
    e.err = !ok;
    e.cycles = ok ? lat : TIMEOUT;
    g.lat = lat; g.hold = hold; g.ov = ov;
    exp_q.push_back(e);
    eng_q.push_back(g);
    in_a = ia; in_b = ib; in_c = ic; in_d = id;
    in_valid = 1'b1;
    taken = 0;
    n = 0;
    while (!taken && n < 1000) begin
      @(negedge clk);
      if (in_ready) taken = 1;
      n++;
    end
    if (!taken) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation bound exceeded");
    $fatal(1);
  end

  initial begin
    int lat, hold, stall, tot_err;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_outputs", {60'd0, start, res_valid, res_err, |res_data}, 64'd0);
    check("reset_operands", {a, b, c, d}, 64'd0);
    check("reset_counters", {32'd0, job_cnt, err_cnt}, 64'd0);
    @(posedge clk); #1;

    // basic job, latency 8
    do_job(16'd10, 16'd20, 16'd1, 16'd5, 8, 0, 0, 32'd155);
    wait_empty();
    check("job_cnt_after_first", 64'(job_cnt), 64'd1);
    check("err_cnt_after_first", 64'(err_cnt), 64'd0);

    // timeout, then done exactly on the last watchdog cycle
    do_job(16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 0, 0, 32'hdead_beef);
    wait_empty();
    check("err_cnt_after_timeout", 64'(err_cnt), 64'd1);
    check("job_cnt_after_timeout", 64'(job_cnt), 64'd2);
    do_job(16'h0a0a, 16'h0b0b, 16'h0c0c, 16'h0d0d, TIMEOUT, 0, 0, 32'h1234_5678);

    // done held after start drops while a second set is waiting
    do_job(16'd7, 16'd8, 16'd9, 16'd10, 4, 5, 0, 32'hcafe_0001);
    do_job(16'd11, 16'd12, 16'd13, 16'd14, 3, 0, 0, 32'hcafe_0002);

    // consumer back-pressure for 20 cycles
    do_job(16'd21, 16'd22, 16'd23, 16'd24, 6, 0, 20, 32'h0bad_f00d);
    wait_empty();
    check("err_cnt_before_reset", 64'(err_cnt), 64'd1);
    check("job_cnt_before_reset", 64'(job_cnt), 64'd6);

    // reset mid-job
    do_job(16'd1, 16'd2, 16'd3, 16'd4, 0, 0, 0, 32'd0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    eng_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midreset_start_valid", {62'd0, start, res_valid}, 64'd0);
    check("midreset_counters", {32'd0, job_cnt, err_cnt}, 64'd0);
    check("midreset_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // back-to-back jobs
    for (int i = 0; i < 3; i++) begin
      do_job(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
             $urandom_range(1, 10), 0, 0, $urandom);
    end
    wait_empty();
    check("job_cnt_back_to_back", 64'(job_cnt), 64'd3);

    // randomized jobs
    tot_err = 0;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 5))
        0: lat = 0;
        1: lat = TIMEOUT;
        2: lat = TIMEOUT + 1;
        default: lat = $urandom_range(1, 20);
      endcase
      if (lat == 0 || lat > TIMEOUT) tot_err++;
      hold = $urandom_range(0, 3);
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      do_job(W'($urandom), W'($urandom), W'($urandom), W'($urandom), lat, hold, stall, $urandom);
    end
    wait_empty();
    check("job_cnt_final", 64'(job_cnt), 64'd19);
    check("err_cnt_final", 64'(err_cnt), 64'(tot_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Host-side initiator for the start/done compute engine (datapath + controller pair). Accepts one operand set (a, b, c, d) at a time over a valid/ready input, drives the engine's operand buses and `start`, and waits for `done`. It then captures the engine's 32-bit `out` and returns it over a valid/ready result port. A watchdog aborts a job whose `done` never arrives and flags the result as an error. The block keeps running counts of completed jobs and timeouts.

## Interface
- `W`, 16, operand width (a, b, c, d)
- `RW`, 32, engine result width
- `TIMEOUT`, 64, maximum cycles `start` is held without `done` before abort (>= 2)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  operand set offered
- `in_ready`  out  1  sequencer accepts an operand set
- `in_a`, `in_b`, `in_c`, `in_d`  in  W each  operands
- `a`, `b`, `c`, `d`  out  W each  registered operands to the engine
- `start`  out  1  engine request, level
- `done`  in  1  engine completion, level
- `out`  in  RW  engine result, valid while `done`=1
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer takes result
- `res_data`  out  RW  captured result (0 on error)
- `res_err`  out  1  result is a timeout abort
- `job_cnt`  out  16  completed jobs (ok + error), wraps
- `err_cnt`  out  16  timeout aborts, wraps

## Operation
- State machine: IDLE, BUSY, RESP, DRAIN.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch `in_a..in_d` into `a..d`, clear the watchdog, go to BUSY.
- BUSY:
  - `start`=1; the watchdog increments every cycle.
  - If `done`=1: `res_data`<=`out`, `res_err`<=0, go to RESP.
  - Otherwise, if watchdog == TIMEOUT-1: `res_data`<=0, `res_err`<=1, go to RESP.
  - If `done` and the timeout land on the same cycle, `done` wins (no error).
- RESP:
  - `start`=0, `res_valid`=1.
  - `res_data` and `res_err` stay stable until the handshake completes.
  - On `res_ready`=1: increment `job_cnt`, and increment `err_cnt` if `res_err`=1. Then go to IDLE if `done`=0, else to DRAIN.
- DRAIN:
  - `start`=0.
  - Wait for `done`=0, then go to IDLE.
  - This prevents a stale `done` from completing the next job.
- Operands `a..d` hold their last latched values outside IDLE acceptance; they never change while `start`=1.
- `in_ready`=1 only in IDLE; there is exactly one job in flight.
- Counters wrap modulo 2^16.
- The watchdog is wide enough for TIMEOUT (clog2).

## Timing
- All outputs are registered or decoded from the state register. There is no combinational path from `in_valid`/`done` to outputs.
- Reset values:
  - state IDLE
  - `start`=0, `res_valid`=0, `res_err`=0, `res_data`=0
  - `a..d`=0, `job_cnt`=0, `err_cnt`=0
  - `in_ready`=1 the cycle after reset
- An input accepted at edge N gives `start`=1 from cycle N+1.
- `done` first sampled high at edge M gives `res_valid`=1 from cycle M+1. `start` falls in the same cycle `res_valid` rises.
- Timeout: `start` stays high for exactly TIMEOUT cycles, then `res_valid`=1 with `res_err`=1.
- Minimum turnaround, result handshake to next `in_ready`: 1 cycle (0 extra if `done` is already low).
- Reset asserted mid-job (any state): next cycle is IDLE, `start`=0, any pending result is discarded, counters are cleared.
- `res_valid` asserted with `res_ready` held low: the block stalls indefinitely, `start` stays 0, and no new input is accepted.

## Test plan
- Engine model raises `done` 8 cycles after `start` with `out`=155. Inputs a=10, b=20, c=1, d=5. Required: `a..d` equal those values with `start` high, `start` high exactly 8 cycles, `res_data`=155, `res_err`=0, `job_cnt`=1.
- Engine never asserts `done`, TIMEOUT=64. Required: `start` high for exactly 64 cycles, then `res_valid`=1, `res_err`=1, `res_data`=0, `err_cnt`=1 after the handshake.
- Engine holds `done` high 5 cycles after `start` drops, while a second operand set is offered. Required: the block sits in DRAIN with `in_ready`=0 until `done`=0, then accepts; the second result is correct.
- `res_ready` held low 20 cycles after the result. Required: `res_data` stable, `start`=0, `in_ready`=0 throughout; the result is accepted on the first `res_ready` cycle.
- `rst` pulsed for 1 cycle while in BUSY. Required: next cycle `start`=0, `res_valid`=0, counters 0; a following job completes normally.
- Back-to-back jobs, 3 sets with `res_ready`=1 always. Required: three results in order, `job_cnt`=3, `in_valid` is never accepted while `start`=1.
